// File: rtl/nibble_serial_add_ctrl.sv
// Serial wide adder controller: feeds an external 4-bit adder one nibble per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            cin_q, cin_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
`ifdef SERIAL_ADD_OVF_EN
    logic            ovf_q, ovf_d;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = result_q;
    assign out_cout  = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign out_ovf   = ovf_q;
`endif

    // Adder drive depends only on registered state so no input reaches the adder combinationally.
    always_comb begin
        add_a   = 4'h0;
        add_b   = 4'h0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (k_q == KW'(i)) begin
                    add_a = a_q[i*4 +: 4];
                    add_b = b_q[i*4 +: 4];
                end
            end
            add_cin = (k_q == '0) ? cin_q : carry_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        carry_d  = carry_q;
        result_d = result_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = in_a;
                    b_d      = in_b;
                    cin_d    = in_cin;
                    k_d      = '0;
                    carry_d  = 1'b0;
                    result_d = '0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = RUN;
                end
            end
            RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (k_q == KW'(i)) begin
                        result_d[i*4 +: 4] = add_sum;
                    end
                end
                carry_d = add_cout;
                if (k_q == K_LAST) begin
                    k_d     = '0;
                    state_d = DONE;
`ifdef SERIAL_ADD_OVF_EN
                    // Overflow: like-signed operands producing a sum of the opposite sign.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[3] != a_q[W-1]);
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            carry_q  <= carry_d;
            result_q <= result_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
# nibble_serial_add_ctrl

Sequencing controller that wraps the 4-bit combinational `adder` stage to perform wide additions one nibble per cycle. It accepts two `4*NIBBLES`-bit operands and a carry-in over a valid/ready handshake, then drives the adder with one nibble pair per cycle, least-significant nibble first, feeding each `carry_out` back as the next `carry_in`. It assembles the wide sum and the final carry, and presents them downstream over a second valid/ready handshake. The block sits directly upstream of the adder (it feeds `a`, `b`, `carry_in`) and directly downstream of it (it consumes `sum` and `carry_out`).

## Interface
- `NIBBLES`, default 4: number of 4-bit digits per operand. Operand width W = 4*NIBBLES. Legal range is 2..8.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  operand bundle valid.
- `in_ready`  output  1  controller can accept operands.
- `in_a`  input  W  operand A.
- `in_b`  input  W  operand B.
- `in_cin`  input  1  carry-in for nibble 0.
- `add_a`  output  4  to adder `a`.
- `add_b`  output  4  to adder `b`.
- `add_cin`  output  1  to adder `carry_in`.
- `add_sum`  input  4  from adder `sum`; combinational in the same cycle.
- `add_cout`  input  1  from adder `carry_out`.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  downstream accepts result.
- `out_sum`  output  W  wide sum.
- `out_cout`  output  1  carry out of the MSB nibble.
- `out_ovf`  output  1  signed overflow; present only with `SERIAL_ADD_OVF_EN`.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `in_a`, `in_b`, `in_cin`; clear the nibble index k to 0; clear the result register; go to RUN.
- **RUN**
  - `in_ready`=0.
  - Drive `add_a`=A[4k+3:4k] and `add_b`=B[4k+3:4k].
  - `add_cin` = latched `in_cin` when k=0, otherwise the carry register.
  - At each edge: result[4k+3:4k] ← `add_sum`; carry register ← `add_cout`; k ← k+1.
  - After the edge that captures k=NIBBLES-1, go to DONE.
- **DONE**
  - `out_valid`=1; `out_sum`=result; `out_cout`=carry register.
  - Outputs stay stable while `out_ready`=0.
  - On `out_valid & out_ready`: go to IDLE.
  - `in_ready` stays 0 in DONE. There is no overlap of consecutive operations.
- Adder drive outside RUN: `add_a`, `add_b`, `add_cin` are driven 0.
- Arithmetic: `{out_cout, out_sum}` = A + B + cin, computed modulo 2^(W+1). The controller itself never adds; every sum bit comes from `add_sum`.
- Input changes: changes on `in_a`, `in_b`, `in_cin` after acceptance have no effect on the operation in flight.
- Reset, including mid-RUN or mid-DONE: the operation is aborted and the FSM returns to IDLE. Reset values:
  - `in_ready`=1;
  - `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_ovf`=0;
  - `add_a`/`add_b`/`add_cin`=0;
  - k=0, carry register=0.

## Timing
- Acceptance edge T0 (IDLE→RUN).
- Nibble k is driven during cycle T0+k and captured at edge T0+k+1.
- `out_valid` rises after edge T0+NIBBLES. Latency is NIBBLES cycles from acceptance to result.
- With `out_ready` held at 1, DONE lasts one cycle, and `in_ready` returns to 1 after edge T0+NIBBLES+1.
- Minimum issue interval: NIBBLES+2 cycles.
- The adder path is combinational. `add_*` outputs must come from registered state only (FSM, k, latched operands, carry register). There is no combinational path from `in_*` to `add_*`.
- `out_sum`, `out_cout` and `out_ovf` are registered outputs.

## Configuration
- Macro: `SERIAL_ADD_OVF_EN`.
- When defined:
  - Port `out_ovf` exists.
  - At the capture edge of nibble NIBBLES-1, `out_ovf` ← (A[W-1] == B[W-1]) & (`add_sum`[3] != A[W-1]).
  - `out_ovf` is held with `out_sum` through DONE and cleared on leaving DONE and on reset.
- When undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- NIBBLES=4, A=0x1234, B=0x4321, cin=0 → after 4 RUN cycles, `out_sum`=0x5555, `out_cout`=0. `add_a` sequence is 4,3,2,1.
- A=0xFFFF, B=0x0001, cin=0 → `out_sum`=0x0000, `out_cout`=1. `add_cin` sequence is 0,1,1,1, confirming carry propagation across all nibbles.
- A=0x000F, B=0x0000, cin=1 → `out_sum`=0x0010, `out_cout`=0. `in_ready`=0 throughout RUN/DONE; an `in_valid` pulse during RUN is ignored.
- Backpressure: 0xAAAA+0x5555, `out_ready` held 0 for 3 cycles after `out_valid` → `out_sum`=0xFFFF stays stable and `out_valid` stays 1. Release → IDLE on the next edge.
- Reset asserted during RUN at k=2 → all outputs immediately take their reset values. A following operation 0x0102+0x0304 gives 0x0406.
- With `SERIAL_ADD_OVF_EN` defined: 0x7FFF+0x0001 → `out_ovf`=1, `out_sum`=0x8000. Then 0x8000+0x8000 → `out_ovf`=1, `out_cout`=1. Then 0x1000+0x1000 → `out_ovf`=0.
